centroid_extract: RTL and testbench
===================================

Name: centroid_extract

Overview:
- Measurement front-end for the tracking pipeline; sits directly upstream of the Kalman filter stage.
- Consumes the per-pixel detection-mask stream from the segmentation stage and accumulates hit coordinates over one frame.
- At frame end, computes the integer centroid with an iterative divider.
- Presents (z_x, z_y) to the filter over a valid/ready handshake.

Parameters:
- DISP_WIDTH, 11, width of pixel coordinates and of output centroid.
- MIN_COUNT, 16, minimum hit pixels in a frame for a measurement to be emitted. Range 1..2^(2*DISP_WIDTH)-1.

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel beat qualifier
- pix_hit  in  1  mask bit; pixel belongs to object (ignored unless pix_valid)
- pix_x  in  DISP_WIDTH  column of current pixel
- pix_y  in  DISP_WIDTH  row of current pixel
- frame_end  in  1  one-cycle pulse, last beat of frame (may coincide with a pixel beat)
- z_x  out  DISP_WIDTH  centroid column
- z_y  out  DISP_WIDTH  centroid row
- valid  out  1  measurement available
- ready  in  1  downstream accepts (filter idle)
- overrun  out  1  one-cycle pulse, frame result discarded because block busy

Behaviour:
- Interface: one clock, clk; reset aresetn is asynchronous and active-low.
- Reset values: all outputs 0; accumulators 0; FSM in ACCUM.
- Widths:
  - CNT_W = 2*DISP_WIDTH (hit counter).
  - SUM_W = 3*DISP_WIDTH (sum_x, sum_y).
  - Unsigned arithmetic; no saturation needed within these widths.
- Accumulation, every cycle independent of FSM state:
  - if pix_valid & pix_hit: sum_x += pix_x, sum_y += pix_y, cnt += 1.
- frame_end at edge k, with pix_valid & pix_hit on the same beat: that pixel is included in the closing frame.
- frame_end at edge k, FSM in ACCUM:
  - If cnt_final >= MIN_COUNT: snapshot final sums/count into divider registers and go to DIVIDE.
  - Otherwise: discard, stay in ACCUM, no valid, no overrun.
  - In both cases accumulators restart at 0, or at the single-beat contribution of a coincident next-frame pixel (none; frame_end is the last beat, so restart at 0).
- frame_end while in DIVIDE or OUTPUT: accumulators cleared, frame discarded, overrun pulses high for exactly the following cycle; in-flight result unaffected.
- DIVIDE: restoring division, x and y in parallel, one quotient bit per cycle, MSB first.
  - Bit i (DISP_WIDTH-1 down to 0): if rem >= (cnt << i) then rem -= (cnt << i), q[i] = 1.
  - Exactly DISP_WIDTH cycles; quotient = floor(sum/cnt), which always fits DISP_WIDTH.
  - Then load z_x/z_y and go to OUTPUT.
- Latency: frame_end sampled at edge k -> valid high after edge k+DISP_WIDTH+1 (12 edges at default).
- OUTPUT:
  - valid = 1; z_x, z_y stable while valid & ~ready.
  - Transfer on an edge with valid & ready; then valid = 0 next cycle and FSM returns to ACCUM.
  - valid never deasserts without transfer except on reset.
- z_x/z_y hold the last delivered value while valid = 0.
- Reset mid-DIVIDE/OUTPUT: immediate return to reset state; partial frame and pending result lost.
- FSM: ACCUM -> DIVIDE (frame_end & cnt>=MIN_COUNT) -> OUTPUT (bit counter expires) -> ACCUM (valid & ready). Illegal encodings -> ACCUM.

Test Plan:
- Single frame, MIN_COUNT=1, one hit at (100,200), ready=1 -> valid one cycle at edge k+12, z=(100,200).
- Hits (10,20),(11,21),(12,22),(13,23), MIN_COUNT=4 -> sums (46,86), cnt 4 -> z=(11,21) (floor).
- Frame with 15 hits, MIN_COUNT=16 -> no valid, no overrun; next frame with 16 hits at (5,7) -> z=(5,7).
- ready held low 20 cycles after valid -> valid and z stable throughout; one transfer when ready rises, valid low next cycle.
- Second frame_end during DIVIDE -> overrun pulse 1 cycle; first frame's centroid still delivered; second frame yields no output.
- Five hits at (2047,2047) plus frame_end coincident with last hit -> z=(2047,2047); aresetn low during DIVIDE of a later frame -> valid=0, z=0, no output after release until a new frame.

Source files
------------

// File: rtl/centroid_extract.sv
// -----------------------------------------------------------------------------
// centroid_extract
//
// Measurement front-end for the tracking pipeline. Accumulates the coordinates
// of every hit pixel in a frame of the segmentation mask stream. At frame end
// it divides the coordinate sums by the hit count with a restoring divider,
// which resolves one quotient bit per cycle for x and y in parallel. The
// resulting integer centroid is offered to the Kalman filter stage over a
// valid/ready handshake.
//
// Ports:
//   clk        system clock
//   aresetn    asynchronous active-low reset
//   pix_valid  pixel beat qualifier
//   pix_hit    mask bit, pixel belongs to the object (ignored unless pix_valid)
//   pix_x      column of the current pixel
//   pix_y      row of the current pixel
//   frame_end  one-cycle pulse on the last beat of a frame; a hit pixel on the
//              same beat belongs to the closing frame
//   z_x, z_y   centroid column / row; hold the last delivered value
//   valid      measurement available; held until taken by ready
//   ready      downstream accepts
//   overrun    one-cycle pulse: a frame closed while the block was busy and
//              its result was dropped
// -----------------------------------------------------------------------------
module centroid_extract #(
    parameter int DISP_WIDTH = 11,
    parameter int MIN_COUNT  = 16
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  pix_valid,
    input  logic                  pix_hit,
    input  logic [DISP_WIDTH-1:0] pix_x,
    input  logic [DISP_WIDTH-1:0] pix_y,
    input  logic                  frame_end,
    output logic [DISP_WIDTH-1:0] z_x,
    output logic [DISP_WIDTH-1:0] z_y,
    output logic                  valid,
    input  logic                  ready,
    output logic                  overrun
);

    localparam int CNT_W  = 2 * DISP_WIDTH;
    localparam int SUM_W  = 3 * DISP_WIDTH;
    localparam int STEP_W = $clog2(DISP_WIDTH + 1);

    localparam logic [CNT_W-1:0]  MIN_CNT = CNT_W'(MIN_COUNT);
    localparam logic [STEP_W-1:0] STEPS   = STEP_W'(DISP_WIDTH);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Running frame accumulators.
    logic [SUM_W-1:0] sum_x, sum_y;
    logic [CNT_W-1:0] cnt;

    // Frame totals including a hit that arrives on the frame_end beat.
    logic             pix_take;
    logic [SUM_W-1:0] sum_x_fin, sum_y_fin;
    logic [CNT_W-1:0] cnt_fin;
    logic             frame_ok;

    // Divider state. step counts the quotient bits still to resolve; the
    // cycle in which it reads zero publishes the quotient.
    logic [SUM_W-1:0]      rem_x, rem_y;
    logic [CNT_W-1:0]      div_cnt;
    logic [STEP_W-1:0]     step;
    logic [DISP_WIDTH-1:0] q_x, q_y;

    logic [STEP_W-1:0] bit_idx;
    logic [SUM_W-1:0]  trial;
    logic              ge_x, ge_y;

    assign pix_take  = pix_valid & pix_hit;
    assign sum_x_fin = sum_x + (pix_take ? SUM_W'(pix_x) : '0);
    assign sum_y_fin = sum_y + (pix_take ? SUM_W'(pix_y) : '0);
    assign cnt_fin   = cnt + CNT_W'(pix_take);
    assign frame_ok  = frame_end && (state == ST_ACCUM) && (cnt_fin >= MIN_CNT);

    // Divisor aligned to the quotient bit under test. The quotient is bounded
    // by the coordinate range, so starting at bit DISP_WIDTH-1 never misses a
    // higher bit and the shifted divisor always fits in SUM_W.
    assign bit_idx = step - STEP_W'(1);
    assign trial   = SUM_W'(div_cnt) << bit_idx;
    assign ge_x    = (rem_x >= trial);
    assign ge_y    = (rem_y >= trial);

    // Accumulators run in every state; frame_end always restarts them, so a
    // frame closing while busy is simply forgotten.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
        end else if (frame_end) begin
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
        end else if (pix_take) begin
            sum_x <= sum_x_fin;
            sum_y <= sum_y_fin;
            cnt   <= cnt_fin;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is given its default before the case so that every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM:  if (frame_ok)     state_nxt = ST_DIVIDE;
            ST_DIVIDE: if (step == '0)   state_nxt = ST_OUTPUT;
            ST_OUTPUT: if (ready)        state_nxt = ST_ACCUM;
            default:                     state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rem_x   <= '0;
            rem_y   <= '0;
            div_cnt <= '0;
            step    <= '0;
            q_x     <= '0;
            q_y     <= '0;
            z_x     <= '0;
            z_y     <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= frame_end && (state != ST_ACCUM);
            case (state)
                ST_ACCUM: begin
                    if (frame_ok) begin
                        rem_x   <= sum_x_fin;
                        rem_y   <= sum_y_fin;
                        div_cnt <= cnt_fin;
                        step    <= STEPS;
                        q_x     <= '0;
                        q_y     <= '0;
                    end
                end
                ST_DIVIDE: begin
                    if (step != '0) begin
                        if (ge_x) rem_x <= rem_x - trial;
                        if (ge_y) rem_y <= rem_y - trial;
                        // MSB-first bits shift in from the right.
                        q_x  <= {q_x[DISP_WIDTH-2:0], ge_x};
                        q_y  <= {q_y[DISP_WIDTH-2:0], ge_y};
                        step <= step - STEP_W'(1);
                    end else begin
                        z_x   <= q_x;
                        z_y   <= q_y;
                        valid <= 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (ready) valid <= 1'b0;
                end
                default: begin
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_extract.sv
// -----------------------------------------------------------------------------
// tb_centroid_extract
//
// Self-checking bench for centroid_extract. The reference model keeps the hit
// pixels of the frame under construction in queues and derives the expected
// centroid with integer arithmetic (floor of sum / count), emitting nothing
// when the frame holds fewer than MIN_CNT hits. The DUT is built with
// MIN_COUNT = 4 so that the threshold boundary is cheap to reach.
// -----------------------------------------------------------------------------
module tb_centroid_extract;

    localparam int DW      = 11;
    localparam int MIN_CNT = 4;
    localparam int LAT     = DW + 1;
    localparam int CMAX    = (1 << DW) - 1;

    logic          clk       = 1'b0;
    logic          aresetn   = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_hit   = 1'b0;
    logic [DW-1:0] pix_x     = '0;
    logic [DW-1:0] pix_y     = '0;
    logic          frame_end = 1'b0;
    logic          ready     = 1'b1;
    logic [DW-1:0] z_x, z_y;
    logic          valid, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Hit pixels of the frame being built.
    int fx[$];
    int fy[$];

    centroid_extract #(
        .DISP_WIDTH (DW),
        .MIN_COUNT  (MIN_CNT)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .pix_valid (pix_valid),
        .pix_hit   (pix_hit),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .frame_end (frame_end),
        .z_x       (z_x),
        .z_y       (z_y),
        .valid     (valid),
        .ready     (ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int x, input int y, input bit v, input bit h, input bit fe);
        pix_valid = v;
        pix_hit   = h;
        pix_x     = DW'(x);
        pix_y     = DW'(y);
        frame_end = fe;
        tick();
        pix_valid = 1'b0;
        pix_hit   = 1'b0;
        frame_end = 1'b0;
    endtask

    // Plays fx/fy as hit beats with random non-hit noise between them. On
    // return the frame_end beat has just been sampled (edge k).
    task automatic send_frame(input bit coincident);
        for (int i = 0; i < fx.size(); i++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    beat($urandom_range(0, CMAX), $urandom_range(0, CMAX), 1'b1, 1'b0, 1'b0);
                else
                    beat($urandom_range(0, CMAX), $urandom_range(0, CMAX), 1'b0, 1'b1, 1'b0);
            end
            beat(fx[i], fy[i], 1'b1, 1'b1, coincident && (i == fx.size() - 1));
        end
        if (!coincident || fx.size() == 0)
            beat($urandom_range(0, CMAX), $urandom_range(0, CMAX), 1'b0, 1'b1, 1'b1);
    endtask

    function automatic void model(output bit emit, output int ex, output int ey);
        int sx = 0;
        int sy = 0;
        int n  = fx.size();
        for (int i = 0; i < n; i++) begin
            sx += fx[i];
            sy += fy[i];
        end
        emit = (n >= MIN_CNT);
        ex   = (n > 0) ? sx / n : 0;
        ey   = (n > 0) ? sy / n : 0;
    endfunction

    task automatic fill_same(input int n, input int x, input int y);
        fx.delete();
        fy.delete();
        for (int i = 0; i < n; i++) begin
            fx.push_back(x);
            fy.push_back(y);
        end
    endtask

    task automatic fill_random(input int n);
        fx.delete();
        fy.delete();
        for (int i = 0; i < n; i++) begin
            fx.push_back($urandom_range(0, CMAX));
            fy.push_back($urandom_range(0, CMAX));
        end
    endtask

    // Waits (bounded) for valid; lat counts edges since the frame_end edge.
    task automatic wait_valid(input int start_lat, output int lat, output bit seen, output bit ovr);
        lat  = start_lat;
        seen = 1'b0;
        ovr  = 1'b0;
        while (!seen && lat < start_lat + 100) begin
            tick();
            lat++;
            if (overrun !== 1'b0) ovr = 1'b1;
            if (valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic expect_result(input int ex, input int ey, input bit rnd_ready,
                                 input int start_lat, input string name);
        int            lat;
        int            guard;
        bit            seen, ovr, done, bad_hold;
        logic [DW-1:0] hx, hy;
        wait_valid(start_lat, lat, seen, ovr);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: valid never rose within 100 cycles", name);
            return;
        end
        n_checks++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d edges, expected %0d", name, lat, LAT);
        end
        n_checks++;
        if (z_x !== DW'(ex) || z_y !== DW'(ey)) begin
            n_fail++;
            $display("FAIL %s_z: got (%0d,%0d), expected (%0d,%0d)", name, z_x, z_y, ex, ey);
        end
        n_checks++;
        if (ovr) begin
            n_fail++;
            $display("FAIL %s_overrun: overrun pulsed while waiting, expected none", name);
        end
        done = 1'b0;
        bad_hold = 1'b0;
        guard = 0;
        hx = z_x;
        hy = z_y;
        while (!done && guard < 100) begin
            ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (guard == 99) ready = 1'b1;
            tick();
            guard++;
            if (ready) done = 1'b1;
            else if (valid !== 1'b1 || z_x !== hx || z_y !== hy) bad_hold = 1'b1;
        end
        n_checks++;
        if (bad_hold) begin
            n_fail++;
            $display("FAIL %s_hold: valid/z changed while ready low, expected stable (%0d,%0d)", name, hx, hy);
        end
        n_checks++;
        if (valid !== 1'b0 || z_x !== DW'(ex) || z_y !== DW'(ey)) begin
            n_fail++;
            $display("FAIL %s_after_xfer: valid=%0b z=(%0d,%0d), expected valid=0 z=(%0d,%0d)",
                     name, valid, z_x, z_y, ex, ey);
        end
        ready = 1'b1;
    endtask

    task automatic expect_none(input int cycles, input string name);
        bit bad_v = 1'b0;
        bit bad_o = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (valid !== 1'b0) bad_v = 1'b1;
            if (overrun !== 1'b0) bad_o = 1'b1;
        end
        n_checks++;
        if (bad_v || bad_o) begin
            n_fail++;
            $display("FAIL %s_quiet: valid seen=%0b overrun seen=%0b, expected neither", name, bad_v, bad_o);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (valid !== 1'b0 || overrun !== 1'b0 || z_x !== '0 || z_y !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b overrun=%0b z=(%0d,%0d), expected all 0",
                     valid, overrun, z_x, z_y);
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        fill_same(MIN_CNT, 100, 200);
        send_frame(1'b0);
        expect_result(100, 200, 1'b0, 0, "basic");
    endtask

    task automatic test_floor();
        fx = '{10, 11, 12, 13};
        fy = '{20, 21, 22, 23};
        send_frame(1'b0);
        expect_result(11, 21, 1'b0, 0, "floor");
    endtask

    task automatic test_min_count();
        fill_same(MIN_CNT - 1, 900, 900);
        send_frame(1'b0);
        expect_none(20, "below_min");
        fill_same(MIN_CNT, 5, 7);
        send_frame(1'b0);
        expect_result(5, 7, 1'b0, 0, "at_min");
    endtask

    task automatic test_backpressure();
        int            lat;
        bit            seen, ovr, bad;
        bit            emit;
        int            ex, ey;
        logic [DW-1:0] hx, hy;
        fill_random(7);
        model(emit, ex, ey);
        ready = 1'b0;
        send_frame(1'b1);
        wait_valid(0, lat, seen, ovr);
        n_checks++;
        if (!seen || lat != LAT || z_x !== DW'(ex) || z_y !== DW'(ey)) begin
            n_fail++;
            $display("FAIL bp_first: seen=%0b lat=%0d z=(%0d,%0d), expected lat %0d z=(%0d,%0d)",
                     seen, lat, z_x, z_y, LAT, ex, ey);
        end
        hx = z_x;
        hy = z_y;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid !== 1'b1 || z_x !== hx || z_y !== hy) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_stable: valid/z moved during 20 stalled cycles, expected valid=1 z=(%0d,%0d)", ex, ey);
        end
        ready = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b0 || z_x !== DW'(ex) || z_y !== DW'(ey)) begin
            n_fail++;
            $display("FAIL bp_release: valid=%0b z=(%0d,%0d), expected valid=0 z=(%0d,%0d)",
                     valid, z_x, z_y, ex, ey);
        end
        expect_none(10, "bp_single");
    endtask

    task automatic test_overrun();
        bit emit;
        int ex, ey;
        fill_random(6);
        model(emit, ex, ey);
        send_frame(1'b0);
        // Second frame closes while the divider is busy (edges k+1..k+4).
        beat(300, 400, 1'b1, 1'b1, 1'b0);
        beat(310, 410, 1'b1, 1'b1, 1'b0);
        beat(320, 420, 1'b1, 1'b1, 1'b0);
        beat(330, 430, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (overrun !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_pulse: overrun=%0b valid=%0b, expected overrun=1 valid=0", overrun, valid);
        end
        tick();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_width: overrun=%0b on second cycle, expected 0", overrun);
        end
        expect_result(ex, ey, 1'b0, 5, "ovr_first");
        expect_none(30, "ovr_second");
    endtask

    task automatic test_max_coincident();
        fill_same(5, CMAX, CMAX);
        send_frame(1'b1);
        expect_result(CMAX, CMAX, 1'b0, 0, "max");
    endtask

    task automatic test_reset_mid();
        bit emit;
        int ex, ey;
        fill_random(8);
        send_frame(1'b0);
        repeat (4) tick();
        #2;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || overrun !== 1'b0 || z_x !== '0 || z_y !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%0b overrun=%0b z=(%0d,%0d), expected all 0",
                     valid, overrun, z_x, z_y);
        end
        tick();
        tick();
        aresetn = 1'b1;
        expect_none(30, "rst_mid_quiet");
        fill_random(9);
        model(emit, ex, ey);
        send_frame(1'b1);
        expect_result(ex, ey, 1'b0, 0, "rst_recover");
    endtask

    task automatic test_random();
        bit emit;
        int ex, ey;
        for (int f = 0; f < 25; f++) begin
            fill_random($urandom_range(0, 10));
            model(emit, ex, ey);
            send_frame(1'($urandom_range(0, 1)));
            if (emit) expect_result(ex, ey, 1'b1, 0, "rand");
            else      expect_none(16, "rand_none");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor();
        test_min_count();
        test_backpressure();
        test_overrun();
        test_max_coincident();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
